// File: rtl/complex_divider.sv
// rtl/complex_divider.sv - multi-cycle fixed-point complex divider a/b = a*conj(b)/|b|^2
module complex_divider #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic               div_zero,
   output logic [2*WIDTH-1:0] result
);
   localparam int HALF = WIDTH / 2;
   localparam int CW   = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, MUL, DIV_RE, DIV_IM, DONE} state_t;

   state_t                 state;
   logic signed [HALF-1:0] ar, ai, br, bi;
   logic [CW-1:0]          cnt;
   logic [WIDTH-1:0]       num;      // numerator magnitude, shifted out MSB first
   logic [WIDTH-1:0]       num_im;   // imaginary magnitude parked until DIV_IM
   logic [WIDTH-1:0]       den;
   logic [WIDTH-1:0]       quo;
   logic [WIDTH-1:0]       q_re;     // signed real quotient held while DIV_IM runs
   logic [WIDTH:0]         rem;
   logic                   neg_re, neg_im;

   logic signed [WIDTH-1:0] ar_x, ai_x, br_x, bi_x;
   logic signed [WIDTH-1:0] p_rr, p_ii, p_ir, p_ri, p_bb, p_cc;
   logic [WIDTH:0]          nre, nim;
   logic [WIDTH-1:0]        den_c, mag_re, mag_im;
   logic [WIDTH:0]          rem_sh, rem_nx;
   logic                    q_bit;
   logic [WIDTH-1:0]        quo_nx, q_signed;
   logic                    q_neg;

   // Cross products of the latched operands and their magnitudes for the MUL step
   always_comb begin
      ar_x   = WIDTH'(ar);
      ai_x   = WIDTH'(ai);
      br_x   = WIDTH'(br);
      bi_x   = WIDTH'(bi);
      p_rr   = ar_x * br_x;
      p_ii   = ai_x * bi_x;
      p_ir   = ai_x * br_x;
      p_ri   = ar_x * bi_x;
      p_bb   = br_x * br_x;
      p_cc   = bi_x * bi_x;
      nre    = {p_rr[WIDTH-1], p_rr} + {p_ii[WIDTH-1], p_ii};
      nim    = {p_ir[WIDTH-1], p_ir} - {p_ri[WIDTH-1], p_ri};
      // both squares are non-negative, so the unsigned sum of up to 2^(WIDTH-1) is exact
      den_c  = p_bb + p_cc;
      mag_re = nre[WIDTH] ? (~nre[WIDTH-1:0] + WIDTH'(1)) : nre[WIDTH-1:0];
      mag_im = nim[WIDTH] ? (~nim[WIDTH-1:0] + WIDTH'(1)) : nim[WIDTH-1:0];
   end

   // One restoring-division step plus sign application of the finished quotient
   always_comb begin
      rem_sh = {rem[WIDTH-1:0], num[WIDTH-1]};
      q_bit  = (rem_sh >= {1'b0, den});
      rem_nx = q_bit ? (rem_sh - {1'b0, den}) : rem_sh;
      quo_nx = {quo[WIDTH-2:0], q_bit};
      q_neg  = (state == DIV_RE) ? neg_re : neg_im;
      // negating a zero magnitude yields zero, so +0 falls out naturally
      q_signed = q_neg ? (WIDTH'(0) - quo_nx) : quo_nx;
   end

   // Control FSM with registered handshake outputs and the shared divider registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         result   <= '0;
         ar       <= '0;
         ai       <= '0;
         br       <= '0;
         bi       <= '0;
         cnt      <= '0;
         num      <= '0;
         num_im   <= '0;
         den      <= '0;
         quo      <= '0;
         q_re     <= '0;
         rem      <= '0;
         neg_re   <= 1'b0;
         neg_im   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ar    <= a[WIDTH-1:HALF];
                  ai    <= a[HALF-1:0];
                  br    <= b[WIDTH-1:HALF];
                  bi    <= b[HALF-1:0];
                  state <= MUL;
                  busy  <= 1'b1;
               end
            end
            MUL: begin
               if (den_c == '0) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  div_zero <= 1'b1;
                  result   <= '0;
               end else begin
                  state  <= DIV_RE;
                  den    <= den_c;
                  num    <= mag_re;
                  num_im <= mag_im;
                  neg_re <= nre[WIDTH];
                  neg_im <= nim[WIDTH];
                  rem    <= '0;
                  quo    <= '0;
                  cnt    <= '0;
               end
            end
            DIV_RE: begin
               rem <= rem_nx;
               num <= {num[WIDTH-2:0], 1'b0};
               quo <= quo_nx;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  // real part finished: restart the same divider on the imaginary magnitude
                  state <= DIV_IM;
                  q_re  <= q_signed;
                  num   <= num_im;
                  rem   <= '0;
                  quo   <= '0;
                  cnt   <= '0;
               end
            end
            DIV_IM: begin
               rem <= rem_nx;
               num <= {num[WIDTH-2:0], 1'b0};
               quo <= quo_nx;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  div_zero <= 1'b0;
                  result   <= {q_re, q_signed};
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_complex_divider.sv
// tb/tb_complex_divider.sv - directed and random checks for complex_divider
module tb_complex_divider;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  a, b;
   logic          busy, done, div_zero;
   logic [2*W-1:0] result;

   int n_chk  = 0;
   int n_fail = 0;

   complex_divider #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .result   (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     ar, ai, br, bi;
      longint exp_re, exp_im;
      logic   exp_dz;
      int     exp_lat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] pack(input int re, input int im);
      logic [15:0] r, i;
      r = 16'(re);
      i = 16'(im);
      return {r, i};
   endfunction

   // wait until the divider is idle, present an op, and count edges until done
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while ((busy || done) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (!done && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   initial begin
      int          lat;
      int          drops;
      int          pulses;
      logic [31:0] er, ei;

      vecs[0] = '{7, 1, 1, 1, 4, -3, 1'b0, 65};
      vecs[1] = '{3, 4, 1, 2, 2, 0, 1'b0, 65};
      vecs[2] = '{-32768, 0, 0, 1, 0, 32768, 1'b0, 65};
      vecs[3] = '{-32768, -32768, -1, 0, 32768, 32768, 1'b0, 65};
      vecs[4] = '{5, 5, 0, 0, 0, 0, 1'b1, 1};
      vecs[5] = '{100, -50, 3, -4, 20, 10, 1'b0, 65};
      vecs[6] = '{-7, 0, 2, 0, -3, 0, 1'b0, 65};
      vecs[7] = '{-32768, -32768, -32768, -32768, 1, 0, 1'b0, 65};
      vecs[8] = '{0, 0, 7, 3, 0, 0, 1'b0, 65};
      vecs[9] = '{32767, 32767, 0, -1, -32767, 32767, 1'b0, 65};

      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_dz", 64'(div_zero), 64'd0);
      chk("reset_result", result, 64'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         do_op(pack(vecs[i].ar, vecs[i].ai), pack(vecs[i].br, vecs[i].bi), lat);
         er = 32'(vecs[i].exp_re);
         ei = 32'(vecs[i].exp_im);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         chk($sformatf("v%0d_re", i), 64'(result[63:32]), 64'(er));
         chk($sformatf("v%0d_im", i), 64'(result[31:0]), 64'(ei));
         chk($sformatf("v%0d_dz", i), 64'(div_zero), 64'(vecs[i].exp_dz));
         @(posedge clk);
         #1 chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
      end

      // start held high across the whole op while a/b change underneath
      @(negedge clk);
      a = pack(7, 1);
      b = pack(1, 1);
      start = 1'b1;
      @(posedge clk);
      #1;
      a = pack(100, -50);
      b = pack(3, -4);
      lat = 0;
      drops = 0;
      while (!done && lat < 200) begin
         if (!busy) drops++;
         @(posedge clk);
         #1 lat++;
      end
      chk("held_busy_drops", 64'(drops), 64'd0);
      chk("held_latency", 64'(lat), 64'd65);
      chk("held_result", result, {32'd4, 32'hFFFF_FFFD});
      @(posedge clk);
      #1;
      chk("held_idle_after_done", 64'(busy), 64'd0);
      chk("held_done_once", 64'(done), 64'd0);
      @(posedge clk);
      #1 chk("held_second_accept", 64'(busy), 64'd1);
      lat = 0;
      pulses = 0;
      while (!done && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
      start = 1'b0;
      chk("held_second_latency", 64'(lat), 64'd65);
      chk("held_second_result", result, {32'd20, 32'd10});
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1 if (done) pulses++;
      end
      chk("held_no_extra_done", 64'(pulses), 64'd0);

      // reset 30 cycles into an op
      @(negedge clk);
      a = pack(3, 4);
      b = pack(1, 2);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (29) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_dz", 64'(div_zero), 64'd0);
      chk("abort_result", result, 64'd0);
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 if (done) pulses++;
      end
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 70; k++) begin
         @(posedge clk);
         #1 if (done) pulses++;
      end
      chk("abort_no_done", 64'(pulses), 64'd0);
      do_op(pack(7, 1), pack(1, 1), lat);
      chk("after_abort_latency", 64'(lat), 64'd65);
      chk("after_abort_result", result, {32'd4, 32'hFFFF_FFFD});

      // random operands against a truncate-toward-zero reference
      for (int k = 0; k < 1000; k++) begin
         logic [31:0] ra, rb;
         int          xr, xi, yr, yi;
         longint      nre, nim, den, qre, qim;
         ra = $urandom;
         rb = $urandom;
         while (rb == 0) rb = $urandom;
         xr = int'($signed(ra[31:16]));
         xi = int'($signed(ra[15:0]));
         yr = int'($signed(rb[31:16]));
         yi = int'($signed(rb[15:0]));
         nre = longint'(xr) * yr + longint'(xi) * yi;
         nim = longint'(xi) * yr - longint'(xr) * yi;
         den = longint'(yr) * yr + longint'(yi) * yi;
         qre = nre / den;
         qim = nim / den;
         do_op(ra, rb, lat);
         er = 32'(qre);
         ei = 32'(qim);
         chk($sformatf("rnd%0d_re a=%h b=%h", k, ra, rb), 64'(result[63:32]), 64'(er));
         chk($sformatf("rnd%0d_im a=%h b=%h", k, ra, rb), 64'(result[31:0]), 64'(ei));
         chk($sformatf("rnd%0d_lat", k), 64'(lat), 64'd65);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end
endmodule
